shifter_pipe_param: RTL and testbench

- Parametrised, pipelined successor to the team's 16-bit left/right barrel-shifter stage.
- Supports any power-of-two WIDTH, logical/arithmetic/rotate modes in both directions, one register per shift level, and a valid/ready handshake with back-pressure.
- Sits between operand sources and the datapath/ALU result mux; the 16-bit instance replaces the combinational shifter where timing requires pipelining.

---
 rtl/shifter_pipe_param.sv | 151 +++++++++++++++
 tb/tb_shifter_pipe_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe_param.sv
// shifter_pipe_param
// Pipelined, width-parametric barrel shifter. It has one register stage per
// bit of the shift amount, and stage k shifts by 2^k when amt[k] is set.
// The valid/ready handshake uses a single global stall: every stage either
// advances together or holds together.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   operand valid
//   in_ready   block accepts an operand this cycle (= advance)
//   a          operand, WIDTH bits
//   amt        shift amount, 0..WIDTH-1
//   dir        0 = left, 1 = right
//   mode       00 logical, 01 arithmetic, 10 rotate, 11 same as 00
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   y          shifted result (registered)
//   y_zero     y == 0, registered alongside y
module shifter_pipe_param #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
);

  // Stage registers. The last stage only needs its data, its valid bit and
  // the zero flag. The control fields are consumed while that stage's
  // register is loaded, so they are kept only for stages 0..AMT_W-2.
  logic [WIDTH-1:0] data_reg  [AMT_W];
  logic             valid_reg [AMT_W];
  logic [AMT_W-1:0] amt_reg   [AMT_W-1];
  logic             dir_reg   [AMT_W-1];
  logic [1:0]       mode_reg  [AMT_W-1];
  logic             sign_reg  [AMT_W-1];
  logic             y_zero_reg;

  // Inputs seen by each stage's shift logic. Stage 0 sees the ports, and
  // stage k sees the register of stage k-1.
  logic [WIDTH-1:0] st_data  [AMT_W];
  logic [AMT_W-1:0] st_amt   [AMT_W];
  logic             st_dir   [AMT_W];
  logic [1:0]       st_mode  [AMT_W];
  logic             st_sign  [AMT_W];
  logic             st_valid [AMT_W];
  logic [WIDTH-1:0] data_next [AMT_W];

  logic advance;

  assign out_valid = valid_reg[AMT_W-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign y         = data_reg[AMT_W-1];
  assign y_zero    = y_zero_reg;

  // Shifts by a fixed power of two when en is set. The fill for an
  // arithmetic right shift comes from the sign bit of the original operand.
  // That sign bit is carried alongside the data, so intermediate stages
  // never need to infer it.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int               sh,
    input logic             en,
    input logic             right,
    input logic [1:0]       md,
    input logic             sign
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      if (md == 2'b10) begin
        if (right) r = (d >> sh) | (d << (WIDTH - sh));
        else       r = (d << sh) | (d >> (WIDTH - sh));
      end else if (right) begin
        r = d >> sh;
        if (md == 2'b01 && sign) r = r | ~({WIDTH{1'b1}} >> sh);
      end else begin
        r = d << sh;
      end
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < AMT_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      if (gi == 0) begin : g_src_port
        assign st_data[gi]  = a;
        assign st_amt[gi]   = amt;
        assign st_dir[gi]   = dir;
        assign st_mode[gi]  = mode;
        assign st_sign[gi]  = a[WIDTH-1];
        assign st_valid[gi] = in_valid;
      end else begin : g_src_stage
        assign st_data[gi]  = data_reg[gi-1];
        assign st_amt[gi]   = amt_reg[gi-1];
        assign st_dir[gi]   = dir_reg[gi-1];
        assign st_mode[gi]  = mode_reg[gi-1];
        assign st_sign[gi]  = sign_reg[gi-1];
        assign st_valid[gi] = valid_reg[gi-1];
      end
      assign data_next[gi] = shift_level(st_data[gi], SH, st_amt[gi][gi],
                                         st_dir[gi], st_mode[gi], st_sign[gi]);
    end
  endgenerate

  // Bubbles (st_valid = 0) flow through like any other entry. Their data is
  // simply never presented as valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < AMT_W; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= '0;
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        amt_reg[k]  <= '0;
        dir_reg[k]  <= 1'b0;
        mode_reg[k] <= 2'b00;
        sign_reg[k] <= 1'b0;
      end
      y_zero_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < AMT_W; k++) begin
        valid_reg[k] <= st_valid[k];
        data_reg[k]  <= data_next[k];
      end
      for (int k = 0; k < AMT_W - 1; k++) begin
        amt_reg[k]  <= st_amt[k];
        dir_reg[k]  <= st_dir[k];
        mode_reg[k] <= st_mode[k];
        sign_reg[k] <= st_sign[k];
      end
      // The zero flag is taken from the final stage's shifter output, so it
      // lands in the same cycle as y.
      y_zero_reg <= (data_next[AMT_W-1] == '0);
    end
  end

endmodule

// File: tb/tb_shifter_pipe_param.sv
// tb_shifter_pipe_param
// Drives WIDTH=8, 16 and 32 instances with shared handshake and control
// signals. Each instance has its own operand and its own scoreboard.
// Expected results come from a whole-amount shift model.
module tb_shifter_pipe_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        dir = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  amt_i = '0;
  logic [31:0] a32 = '0;
  logic [15:0] a16 = '0;
  logic [7:0]  a8 = '0;

  logic        ir8, ir16, ir32, ov8, ov16, ov32, yz8, yz16, yz32;
  logic [7:0]  y8;
  logic [15:0] y16;
  logic [31:0] y32;

  always #5 clk = ~clk;

  shifter_pipe_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir8), .a(a8),
    .amt(amt_i[2:0]), .dir(dir), .mode(mode), .out_valid(ov8),
    .out_ready(out_ready), .y(y8), .y_zero(yz8));
  shifter_pipe_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir16), .a(a16),
    .amt(amt_i[3:0]), .dir(dir), .mode(mode), .out_valid(ov16),
    .out_ready(out_ready), .y(y16), .y_zero(yz16));
  shifter_pipe_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir32), .a(a32),
    .amt(amt_i), .dir(dir), .mode(mode), .out_valid(ov32),
    .out_ready(out_ready), .y(y32), .y_zero(yz32));

  // Index 0 = WIDTH 8, 1 = WIDTH 16, 2 = WIDTH 32.
  logic        ov [3];
  logic        ir [3];
  logic        yz [3];
  logic [31:0] yv [3];
  logic [31:0] av [3];
  logic [4:0]  amv [3];
  assign ov[0] = ov8;  assign ov[1] = ov16; assign ov[2] = ov32;
  assign ir[0] = ir8;  assign ir[1] = ir16; assign ir[2] = ir32;
  assign yz[0] = yz8;  assign yz[1] = yz16; assign yz[2] = yz32;
  assign yv[0] = {24'b0, y8};
  assign yv[1] = {16'b0, y16};
  assign yv[2] = y32;
  assign av[0] = {24'b0, a8};
  assign av[1] = {16'b0, a16};
  assign av[2] = a32;
  assign amv[0] = {2'b0, amt_i[2:0]};
  assign amv[1] = {1'b0, amt_i[3:0]};
  assign amv[2] = amt_i;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] q [3][$];
  logic [31:0] last_y [3];
  logic        last_z [3];
  int          pops [3];
  int          first_pop [3];
  int          last_pop [3];
  logic        held [3];
  logic [31:0] held_y [3];
  logic [31:0] e_cmp;
  int          lat [3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Reference: shift by the whole amount in one step on a wide vector.
  function automatic logic [31:0] model(input int w, input logic [31:0] x_in,
                                        input int am, input logic d, input logic [1:0] m);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x = {32'b0, x_in} & mask;
    if (am == 0) return x[31:0];
    if (m == 2'b10) r = d ? ((x >> am) | (x << (w - am))) : ((x << am) | (x >> (w - am)));
    else if (d) begin
      r = x >> am;
      if (m == 2'b01 && x[w-1]) r = r | (mask & ~(mask >> am));
    end else r = x << am;
    r = r & mask;
    return r[31:0];
  endfunction

  // Single compare process. Outputs are sampled on the falling edge, the
  // middle of each cycle.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        q[k].delete();
        held[k] = 1'b0;
      end else begin
        if (held[k]) begin
          check($sformatf("hold_valid_w%0d", 8 << k), {31'b0, ov[k]}, 32'd1);
          check($sformatf("hold_y_w%0d", 8 << k), yv[k], held_y[k]);
        end
        held[k] = ov[k] & ~out_ready;
        held_y[k] = yv[k];
        if (ov[k] && out_ready) begin
          if (q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL orphan_w%0d: got result %h expected no result", 8 << k, yv[k]);
          end else begin
            e_cmp = q[k].pop_front();
            check($sformatf("y_w%0d", 8 << k), yv[k], e_cmp);
            check($sformatf("yz_w%0d", 8 << k), {31'b0, yz[k]}, {31'b0, e_cmp == 32'd0});
            last_y[k] = yv[k];
            last_z[k] = yz[k];
            if (pops[k] == 0) first_pop[k] = cyc;
            last_pop[k] = cyc;
            pops[k]++;
          end
        end
        if (in_valid && ir[k])
          q[k].push_back(model(8 << k, av[k], int'(amv[k]), dir, mode));
      end
    end
  end

  // Call at posedge+1. Returns at posedge+1 after the 16-bit instance accepts.
  task automatic send(input logic [31:0] x32, input logic [15:0] x16, input logic [7:0] x8,
                      input logic [4:0] am, input logic d, input logic [1:0] m);
    int   g;
    logic acc;
    g = 0;
    a32 = x32; a16 = x16; a8 = x8; amt_i = am; dir = d; mode = m;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = ir16;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 50);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", g);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0) && n < 80);
    if (n >= 80) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0",
               q[0].size(), q[1].size(), q[2].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_chk(input logic [31:0] x32, input logic [15:0] x16, input logic [7:0] x8,
                           input logic [4:0] am, input logic d, input logic [1:0] m,
                           input logic [31:0] e32, input logic [15:0] e16, input logic [7:0] e8,
                           input string nm);
    send(x32, x16, x8, am, d, m);
    wait_drain();
    check({nm, "_w8"},  last_y[0], {24'b0, e8});
    check({nm, "_w16"}, last_y[1], {16'b0, e16});
    check({nm, "_w32"}, last_y[2], e32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      pops[k] = 0; first_pop[k] = 0; last_pop[k] = 0; last_y[k] = '0; last_z[k] = 1'b0;
      held[k] = 1'b0; held_y[k] = '0; lat[k] = 0;
    end
    // Reset state.
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid_w%0d", 8 << k), {31'b0, ov[k]}, 32'd0);
      check($sformatf("rst_y_w%0d", 8 << k), yv[k], 32'd0);
      check($sformatf("rst_in_ready_w%0d", 8 << k), {31'b0, ir[k]}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model itself against hand-computed values.
    check("model_arith16", model(16, 32'h8000, 3, 1'b1, 2'b01), 32'h0000F000);
    check("model_rotr16",  model(16, 32'h8001, 4, 1'b1, 2'b10), 32'h00001800);
    check("model_rotl8",   model(8,  32'h81,   4, 1'b0, 2'b10), 32'h00000018);

    // Latency: the first accept edge counts as cycle 1.
    a32 = 32'h80000001; a16 = 16'h8001; a8 = 8'h81;
    amt_i = 5'd1; dir = 1'b0; mode = 2'b00; in_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) in_valid = 1'b0;
      for (int k = 0; k < 3; k++)
        if (ov[k] && lat[k] == 0) lat[k] = n;
    end
    check("latency_w8",  lat[0], 32'd3);
    check("latency_w16", lat[1], 32'd4);
    check("latency_w32", lat[2], 32'd5);
    wait_drain();
    check("shl1_w16", last_y[1], 32'h0002);
    check("shl1_z_w16", {31'b0, last_z[1]}, 32'd0);

    // Mode and direction checks.
    issue_chk(32'h80000000, 16'h8000, 8'h80, 5'd3, 1'b1, 2'b01,
              32'hF0000000, 16'hF000, 8'hF0, "asr3");
    issue_chk(32'h80000000, 16'h8000, 8'h80, 5'd3, 1'b1, 2'b00,
              32'h10000000, 16'h1000, 8'h10, "lsr3");
    issue_chk(32'h80000000, 16'h8000, 8'h80, 5'd3, 1'b1, 2'b11,
              32'h10000000, 16'h1000, 8'h10, "rsv3");
    issue_chk(32'h80000001, 16'h8001, 8'h81, 5'd4, 1'b1, 2'b10,
              32'h18000000, 16'h1800, 8'h18, "rotr4");
    issue_chk(32'h80000001, 16'h8001, 8'h81, 5'd4, 1'b0, 2'b10,
              32'h00000018, 16'h0018, 8'h18, "rotl4");
    for (int m = 0; m < 4; m++)
      for (int d = 0; d < 2; d++)
        issue_chk(32'h12345678, 16'h1234, 8'h12, 5'd0, d[0], m[1:0],
                  32'h12345678, 16'h1234, 8'h12, $sformatf("amt0_m%0d_d%0d", m, d));

    // Eight back-to-back operands with no stall.
    pops[1] = 0;
    for (int i = 0; i < 8; i++)
      send(32'hA5C30F1E ^ (i * 32'h13579BDF), 16'h5AC3 ^ 16'(i * 16'h1357),
           8'h3C ^ 8'(i * 8'h25), 5'((i * 5 + 3) & 31), i[0] ^ i[1], i[1:0]);
    wait_drain();
    check("stream_count_w16", pops[1], 32'd8);
    check("stream_span_w16", last_pop[1] - first_pop[1], 32'd7);

    // Eight more operands with out_ready low for three edges mid-stream.
    pops[1] = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h0F0F1234 + i * 32'h01010101, 16'hC001 + 16'(i * 16'h0111),
               8'h91 + 8'(i * 8'h13), 5'((i * 7 + 1) & 31), i[0], 2'(i + 1));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          #1;
          check("stall_in_ready_w16", {31'b0, ir16}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_count_w16", pops[1], 32'd8);

    // Asynchronous reset with results in flight.
    for (int i = 0; i < 5; i++)
      send(32'h11111111 * (i + 1), 16'h1111 * 16'(i + 1), 8'h11 * 8'(i + 1), 5'd1, 1'b0, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_rst_valid_w%0d", 8 << k), {31'b0, ov[k]}, 32'd0);
      check($sformatf("async_rst_y_w%0d", 8 << k), yv[k], 32'd0);
      check($sformatf("async_rst_yz_w%0d", 8 << k), {31'b0, yz[k]}, 32'd0);
      pops[k] = 0;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready_w16", {31'b0, ir16}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("no_stale_w%0d", 8 << k), pops[k], 32'd0);

    // Zero result flag.
    issue_chk(32'h00000001, 16'h0001, 8'h01, 5'd1, 1'b1, 2'b00,
              32'h0, 16'h0, 8'h0, "zero");
    for (int k = 0; k < 3; k++)
      check($sformatf("zero_flag_w%0d", 8 << k), {31'b0, last_z[k]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
